// File: rtl/param_universal_shift_register_if.sv
// Data/status bundle for the universal shift register; master drives controls, slave is the register.
// The parity output exists only when USR_PARITY_EN is defined.
interface param_universal_shift_register_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [2:0]       mode;
  logic             sin;
  logic [WIDTH-1:0] din;
  logic             start;
  logic             msb_first;
  logic [WIDTH-1:0] dout;
  logic             sout;
  logic             busy;
  logic             done;
`ifdef USR_PARITY_EN
  logic             parity;
`endif

  modport master (
`ifdef USR_PARITY_EN
    input  parity,
`endif
    output en, mode, sin, din, start, msb_first,
    input  dout, sout, busy, done
  );

  modport slave (
`ifdef USR_PARITY_EN
    output parity,
`endif
    input  en, mode, sin, din, start, msb_first,
    output dout, sout, busy, done
  );
endinterface

// File: rtl/param_universal_shift_register.sv
// WIDTH-bit universal shift register (hold/load/shift/rotate/asr/clear) with an autonomous burst serialiser.
// Optional USR_PARITY_EN adds an XOR-reduction parity output of dout.
module param_universal_shift_register #(
  parameter int WIDTH = 8
) (
  input logic                              clk,
  input logic                              reset,
  param_universal_shift_register_if.slave  bus
);
  localparam int N     = WIDTH - 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      reg_q   <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          reg_d   = bus.din;
          cnt_d   = CNT_W'(WIDTH);
          dir_d   = bus.msb_first;
          sout_d  = 1'b0;
          state_d = BURST;
        end else if (bus.en) begin
          case (bus.mode)
            3'b000: sout_d = 1'b0;
            3'b001: begin
              reg_d  = bus.din;
              sout_d = 1'b0;
            end
            3'b010: begin
              reg_d  = {reg_q[N-1:0], bus.sin};
              sout_d = reg_q[N];
            end
            3'b011: begin
              reg_d  = {bus.sin, reg_q[N:1]};
              sout_d = reg_q[0];
            end
            3'b100: begin
              reg_d  = {reg_q[N-1:0], reg_q[N]};
              sout_d = reg_q[N];
            end
            3'b101: begin
              reg_d  = {reg_q[0], reg_q[N:1]};
              sout_d = reg_q[0];
            end
            3'b110: begin
              reg_d  = {reg_q[N], reg_q[N:1]};
              sout_d = reg_q[0];
            end
            default: begin
              reg_d  = '0;
              sout_d = 1'b0;
            end
          endcase
        end
      end
      BURST: begin
        // Controls are ignored here; the counter alone decides when the burst ends.
        if (dir_q) begin
          sout_d = reg_q[N];
          reg_d  = {reg_q[N-1:0], bus.sin};
        end else begin
          sout_d = reg_q[0];
          reg_d  = {bus.sin, reg_q[N:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dout = reg_q;
  assign bus.sout = sout_q;
  assign bus.busy = (state_q == BURST);
  assign bus.done = done_q;
`ifdef USR_PARITY_EN
  assign bus.parity = ^reg_q;
`endif
endmodule

// File: tb/tb_param_universal_shift_register.sv
// Directed-vector bench for param_universal_shift_register at WIDTH=8.
module tb_param_universal_shift_register;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  param_universal_shift_register_if #(.WIDTH(8)) bus ();

  param_universal_shift_register #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] m, input logic [7:0] d, input logic s);
    bus.en   = 1'b1;
    bus.mode = m;
    bus.din  = d;
    bus.sin  = s;
    tick();
    bus.en   = 1'b0;
  endtask

  // seq lists the expected sout bits left to right: bit k appears in seq[7-k].
  task automatic run_burst(input logic [7:0] d, input logic msbf, input logic s, input logic [7:0] seq);
    bus.din       = d;
    bus.msb_first = msbf;
    bus.sin       = s;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    chk("burst_busy_rise", 32'(bus.busy), 32'd1);
    chk("burst_done_early", 32'(bus.done), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("burst_sout_%0d", k), 32'(bus.sout), 32'(seq[7-k]));
      chk($sformatf("burst_busy_%0d", k), 32'(bus.busy), 32'(k < 7));
      chk($sformatf("burst_done_%0d", k), 32'(bus.done), 32'(k == 7));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.en = 1'b0;
    bus.mode = 3'b000;
    bus.sin = 1'b0;
    bus.din = 8'h00;
    bus.start = 1'b0;
    bus.msb_first = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset mid-operation clears outputs without a clock edge.
    do_op(3'b001, 8'h77, 1'b0);
    chk("load77", 32'(bus.dout), 32'h77);
    bus.en = 1'b1; bus.mode = 3'b010; bus.sin = 1'b1;
    tick();
    chk("shl77", 32'(bus.dout), 32'hEF);
    #2 reset = 1'b1;
    #1;
    chk("rst_dout", 32'(bus.dout), 32'h00);
    chk("rst_sout", 32'(bus.sout), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    bus.en = 1'b0;
    #1 reset = 1'b0;

    // Mode operations.
    do_op(3'b001, 8'hA5, 1'b0);
    chk("load_a5", 32'(bus.dout), 32'hA5);
    chk("load_sout", 32'(bus.sout), 32'd0);
    do_op(3'b100, 8'h00, 1'b0);
    chk("rotl", 32'(bus.dout), 32'h4B);
    chk("rotl_sout", 32'(bus.sout), 32'd1);
`ifdef USR_PARITY_EN
    chk("parity_4b", 32'(bus.parity), 32'd0);
`endif
    do_op(3'b001, 8'hA5, 1'b0);
    do_op(3'b101, 8'h00, 1'b0);
    chk("rotr", 32'(bus.dout), 32'hD2);
    chk("rotr_sout", 32'(bus.sout), 32'd1);
    do_op(3'b001, 8'h80, 1'b0);
    do_op(3'b110, 8'h00, 1'b0);
    chk("asr", 32'(bus.dout), 32'hC0);
    chk("asr_sout", 32'(bus.sout), 32'd0);
    do_op(3'b001, 8'h81, 1'b0);
    do_op(3'b010, 8'h00, 1'b1);
    chk("shl", 32'(bus.dout), 32'h03);
    chk("shl_sout", 32'(bus.sout), 32'd1);
    bus.mode = 3'b111;
    tick();
    chk("idle_hold_dout", 32'(bus.dout), 32'h03);
    chk("idle_hold_sout", 32'(bus.sout), 32'd1);
    do_op(3'b000, 8'h00, 1'b0);
    chk("mode_hold_dout", 32'(bus.dout), 32'h03);
    chk("mode_hold_sout", 32'(bus.sout), 32'd0);
    do_op(3'b001, 8'h3C, 1'b0);
    do_op(3'b011, 8'h00, 1'b1);
    chk("shr", 32'(bus.dout), 32'h9E);
    do_op(3'b111, 8'h00, 1'b0);
    chk("clear", 32'(bus.dout), 32'h00);

    // MSB-first burst.
    run_burst(8'hB4, 1'b1, 1'b0, 8'hB4);
    chk("burst1_dout", 32'(bus.dout), 32'h00);
    tick();
    chk("burst1_done_pulse", 32'(bus.done), 32'd0);
    chk("burst1_sout_hold", 32'(bus.sout), 32'd0);

    // LSB-first burst with clear requested throughout; clear lands only after busy falls.
    bus.en = 1'b1; bus.mode = 3'b111;
    run_burst(8'hB4, 1'b0, 1'b1, 8'h2D);
    chk("burst2_dout", 32'(bus.dout), 32'hFF);
    tick();
    chk("burst2_clear", 32'(bus.dout), 32'h00);
    bus.en = 1'b0;

    // Reset after the third burst bit aborts without done.
    bus.din = 8'hB4; bus.msb_first = 1'b1; bus.sin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    chk("abort_bit2", 32'(bus.sout), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_dout", 32'(bus.dout), 32'h00);
    chk("abort_sout", 32'(bus.sout), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    repeat (2) tick();
    chk("abort_done_late", 32'(bus.done), 32'd0);
    #1 reset = 1'b0;
    run_burst(8'h5A, 1'b1, 1'b0, 8'h5A);

    // start held high: one IDLE cycle between bursts.
    tick();
    bus.din = 8'hC3; bus.msb_first = 1'b1; bus.sin = 1'b0; bus.start = 1'b1;
    tick();
    repeat (8) tick();
    chk("b2b_busy_fall", 32'(bus.busy), 32'd0);
    chk("b2b_done", 32'(bus.done), 32'd1);
    tick();
    bus.start = 1'b0;
    chk("b2b_busy_again", 32'(bus.busy), 32'd1);
    chk("b2b_reload", 32'(bus.dout), 32'hC3);
    repeat (8) tick();
    chk("b2b_done2", 32'(bus.done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
